// File: rtl/chess_pkg.sv
// rtl/chess_pkg.sv - shared move-generator constants, move field layout and arbiter state encoding
// Ports: none (package). Imported by the arbiter, its interface and rr_pick.
package chess_pkg;

    localparam int NCOL  = 8;
    localparam int SLOTS = 8;
    localparam int MOVEW = 19;
    localparam int WORDW = SLOTS * MOVEW;
    localparam int PTRW  = 3;

    // Move flag bit positions
    localparam int F_INVALID = 18;
    localparam int F_PROMOTE = 17;
    localparam int F_PAWN    = 16;
    localparam int F_PAWN2   = 15;
    localparam int F_EP      = 14;
    localparam int F_CASTLE  = 13;
    localparam int F_CAPTURE = 12;

    // Move field ranges
    localparam int FROM_HI = 11;
    localparam int FROM_LO = 6;
    localparam int TO_HI   = 5;
    localparam int TO_LO   = 0;

    typedef logic [MOVEW-1:0] move_t;

    typedef enum logic [2:0] {
        IDLE,
        CLR,
        RUN,
        READ,
        UNPACK,
        DONE
    } arb_state_t;

    function automatic logic move_is_invalid(input move_t m);
        return m[F_INVALID];
    endfunction

endpackage

// File: rtl/board_move_arbiter_if.sv
// rtl/board_move_arbiter_if.sv - valid/ready move stream from the arbiter to the search/eval stage
// Signals: mv_data (MOVEW), mv_valid, mv_ready. master = arbiter side, slave = consumer side.
interface board_move_arbiter_if;
    import chess_pkg::*;

    logic [MOVEW-1:0] mv_data;
    logic             mv_valid;
    logic             mv_ready;

    modport master (output mv_data, output mv_valid, input mv_ready);
    modport slave  (input mv_data, input mv_valid, output mv_ready);
endinterface

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin first-requester finder
// Ports: req (NCOL) requests, ptr (PTRW) search start; grant (NCOL) one-hot, found = any request.
module rr_pick
    import chess_pkg::*;
(
    input  logic [NCOL-1:0] req,
    input  logic [PTRW-1:0] ptr,
    output logic [NCOL-1:0] grant,
    output logic            found
);

    int idx;

    // Scan from ptr upward, wrapping, and keep only the first hit.
    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = 0;
        for (int i = 0; i < NCOL; i++) begin
            idx = (int'(ptr) + i) % NCOL;
            if (!found && req[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/board_move_arbiter.sv
// rtl/board_move_arbiter.sv - launches column move generation and streams valid moves from all column FIFOs
// Ports: clk, reset (sync active-high), start; col_reset pulse; col_done/col_empty per column;
//        col_rden one-hot FIFO read; col_dout concatenated FIFO words; mv (master move stream);
//        busy, done; move_count (live only when MOVE_COUNT_EN is defined, otherwise 0).
module board_move_arbiter
    import chess_pkg::*;
(
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    output logic                   col_reset,
    input  logic [NCOL-1:0]        col_done,
    input  logic [NCOL-1:0]        col_empty,
    output logic [NCOL-1:0]        col_rden,
    input  logic [NCOL*WORDW-1:0]  col_dout,
    board_move_arbiter_if.master   mv,
    output logic                   busy,
    output logic                   done,
    output logic [7:0]             move_count
);

    arb_state_t      state, state_next;
    logic [PTRW-1:0] rr_ptr;
    logic [PTRW-1:0] col_sel;
    logic [PTRW-1:0] grant_idx;
    logic [PTRW-1:0] slot_idx;
    logic [WORDW-1:0] word;
    logic [NCOL-1:0] req;
    logic [NCOL-1:0] grant;
    logic            found;
    move_t           cur_slot;
    move_t           mv_data_r;
    logic            mv_valid_r;
    logic            slot_adv;
    logic            last_slot;

    assign req = ~col_empty;

    rr_pick u_rr_pick (
        .req   (req),
        .ptr   (rr_ptr),
        .grant (grant),
        .found (found)
    );

    always_comb begin
        grant_idx = '0;
        for (int i = 0; i < NCOL; i++) begin
            if (grant[i]) grant_idx = PTRW'(i);
        end
    end

    assign cur_slot  = word[int'(slot_idx)*MOVEW +: MOVEW];
    // A slot may only move on when the output register is free or being drained.
    assign slot_adv  = (state == UNPACK) && (!mv_valid_r || mv.mv_ready);
    assign last_slot = (slot_idx == PTRW'(SLOTS-1));

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        col_reset  = 1'b0;
        col_rden   = '0;
        busy       = 1'b1;
        done       = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) state_next = CLR;
            end
            CLR: begin
                col_reset  = 1'b1;
                state_next = RUN;
            end
            RUN: begin
                if (found) begin
                    col_rden   = grant;
                    state_next = READ;
                end else if (&col_done && &col_empty && !mv_valid_r) begin
                    state_next = DONE;
                end
            end
            READ:   state_next = UNPACK;
            UNPACK: if (slot_adv && last_slot) state_next = RUN;
            DONE: begin
                busy = 1'b0;
                done = 1'b1;
                if (start) state_next = CLR;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr     <= '0;
            col_sel    <= '0;
            word       <= '0;
            slot_idx   <= '0;
            mv_data_r  <= '0;
            mv_valid_r <= 1'b0;
        end else begin
            case (state)
                CLR: rr_ptr <= '0;
                RUN: begin
                    if (found) begin
                        col_sel <= grant_idx;
                        rr_ptr  <= PTRW'((int'(grant_idx) + 1) % NCOL);
                    end
                end
                READ: begin
                    word     <= col_dout[int'(col_sel)*WORDW +: WORDW];
                    slot_idx <= '0;
                end
                UNPACK: if (slot_adv) slot_idx <= slot_idx + 1'b1;
                default: ;
            endcase

            if (slot_adv && !move_is_invalid(cur_slot)) begin
                mv_data_r  <= cur_slot;
                mv_valid_r <= 1'b1;
            end else if (mv.mv_ready) begin
                mv_valid_r <= 1'b0;
            end
        end
    end

    assign mv.mv_data  = mv_data_r;
    assign mv.mv_valid = mv_valid_r;

`ifdef MOVE_COUNT_EN
    logic [7:0] cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else if (state == CLR) begin
            cnt <= '0;
        end else if (mv_valid_r && mv.mv_ready && cnt != 8'hFF) begin
            cnt <= cnt + 8'd1;
        end
    end

    assign move_count = cnt;
`else
    assign move_count = '0;
`endif

endmodule

// File: doc/board_move_arbiter.md
Name: board_move_arbiter

Overview:
- Board-level scheduler for the eight column units.
- Launches move generation by pulsing a shared column reset, then round-robin drains each column's 152-bit move FIFO.
- Unpacks each FIFO word into 19-bit moves, discards invalid slots and streams valid moves on a single valid/ready port to the search/eval stage.
- Signals completion once every column reports done and all FIFOs are empty.

Parameters:
- NCOL, 8, number of column units (one per file).
- SLOTS, 8, move slots per column FIFO word.
- MOVEW, 19, move width: [7b flag][6b from][6b to]; flag MSB = invalid.

Ports:
- clk  in  1  system clock, all logic on posedge.
- reset  in  1  synchronous, active-high; clears all state.
- start  in  1  begin a generation pass; sampled only in IDLE.
- col_reset  out  1  one-cycle pulse to all column units' reset.
- col_done  in  NCOL  per-column done flags; bit i = column xpos i.
- col_empty  in  NCOL  per-column FIFO empty flags.
- col_rden  out  NCOL  one-hot FIFO read enable.
- col_dout  in  NCOL*SLOTS*MOVEW  concatenated FIFO outputs; column i at [152i+151:152i].
- mv_data  out  MOVEW  current move.
- mv_valid  out  1  mv_data valid.
- mv_ready  in  1  downstream accepts move.
- busy  out  1  high in any state except IDLE/DONE.
- done  out  1  high in DONE until next accepted start or reset.
- move_count  out  8  valid moves emitted this pass (see Optional Feature).

Behaviour:
- Reset values: col_reset=0, col_rden=0, mv_data=0, mv_valid=0, busy=0, done=0, move_count=0, state=IDLE, rr_ptr=0, slot_idx=0.
- Reset mid-operation: return to IDLE next edge; a partially unpacked word is dropped.
- IDLE: start=1 -> CLR.
- CLR: col_reset=1 for exactly this cycle; rr_ptr=0 -> RUN.
- RUN:
  - Search from rr_ptr, wrapping 7->0, for the first column with col_empty=0.
  - If found (column k): col_rden[k]=1 this cycle, latch k, rr_ptr<=k+1 mod NCOL -> READ.
  - Else if &col_done and &col_empty and mv_valid=0 -> DONE.
  - Else stay.
- READ: FIFO read latency is 1. Capture col_dout slice k into word register, slot_idx=0 -> UNPACK. col_rden=0.
- UNPACK:
  - Slot s = word[19s+18:19s]; slots are processed ascending 0..7.
  - A slot advances only in a cycle where mv_valid=0 or mv_ready=1.
  - Slot bit18=1: skipped, consumes the cycle, no output.
  - Slot bit18=0: loaded into mv_data, mv_valid<=1.
  - After slot 7 advances -> RUN.
  - mv_valid clears when mv_ready=1 and no new valid slot loads that cycle.
- Output port: mv_data/mv_valid are registered; mv_data holds stable while mv_valid=1 and mv_ready=0.
  - mv_valid may remain high across the UNPACK->RUN transition until consumed.
  - RUN may issue the next read while mv_valid=1.
- DONE: done=1, busy=0. start=1 -> CLR and done clears the same edge.
- start outside IDLE/DONE is ignored.
- At most one col_rden bit high, and never in two consecutive cycles.
- Column asserting done with a non-empty FIFO: still drained before DONE.

Optional Feature:
- Macro: MOVE_COUNT_EN.
- Defined:
  - 8-bit move_count cleared in CLR.
  - Increments on each mv_valid&&mv_ready handshake.
  - Saturates at 255.
  - Holds in DONE.
- Undefined: move_count tied to 0; counter logic absent.

Decomposition:
- Shared package chess_pkg:
  - Move flag bit positions: INVALID=18, PROMOTE=17, PAWN=16, PAWN2=15, EP=14, CASTLE=13, CAPTURE=12.
  - Move field ranges: FROM=[11:6], TO=[5:0].
  - NCOL, SLOTS, MOVEW.
  - Arbiter state encoding: IDLE, CLR, RUN, READ, UNPACK, DONE.
- One sub-module: rr_pick, combinational round-robin first-nonempty finder (req NCOL, ptr 3b -> grant one-hot, found).

Test Plan:
- Reset then start with all col_empty=8'hFF, col_done=8'hFF -> col_reset pulse at cycle 1, DONE by cycle 3, done=1, mv_valid never asserted.
- Column 3 word: slot0=19'h00A1C, slot1=invalid (bit18=1), slot2..7 invalid, mv_ready=1 -> exactly one move 19'h00A1C, then DONE when empty/done high, move_count=1 (MOVE_COUNT_EN).
- Columns 2 and 5 non-empty with rr_ptr=4 -> col_rden[5] first, then col_rden[2] (wrap), never both high.
- Eight valid slots, mv_ready held 0 for 5 cycles after first move -> mv_data stable at slot0 value, then slots 1..7 one per cycle once mv_ready=1.
- reset asserted during UNPACK at slot 4 -> next cycle all outputs 0, state IDLE; subsequent start runs a clean pass.
- col_done=8'hFF while col_empty[6]=0 -> column 6 drained before done asserts; start pulsed during RUN ignored (no extra col_reset).
